// File: rtl/lms_pkg.sv
// Shared definitions for the LMS coefficient updater: default sizes, FSM
// encoding and the saturation helper used by the per-tap MAC.
package lms_pkg;

  localparam int DEF_DIN_WIDTH = 16;
  localparam int DEF_ERR_WIDTH = 16;
  localparam int DEF_TAPS      = 8;
  localparam int DEF_MU_SHIFT  = 10;

  localparam int PROD_WIDTH = DEF_DIN_WIDTH + DEF_ERR_WIDTH;
  localparam int IDX_WIDTH  = $clog2(DEF_TAPS);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_UPDATE = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

  // Clamp a sign-extended value into the signed range of 'width' bits.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] value,
                                                input int                  width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    logic signed [63:0] result;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) begin
      result = max_v;
    end else if (value < min_v) begin
      result = min_v;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/lms_sat_mac.sv
// Single-tap LMS step: coeff + ((x * err) >>> MU_SHIFT), saturated back to the
// coefficient width. Purely combinational; the top time-shares one instance.
module lms_sat_mac
  import lms_pkg::*;
#(
  parameter int DIN_WIDTH = DEF_DIN_WIDTH,
  parameter int ERR_WIDTH = DEF_ERR_WIDTH,
  parameter int MU_SHIFT  = DEF_MU_SHIFT
) (
  input  logic signed [DIN_WIDTH-1:0] coeff,
  input  logic signed [DIN_WIDTH-1:0] x,
  input  logic signed [ERR_WIDTH-1:0] err,
  output logic signed [DIN_WIDTH-1:0] coeff_next
);

  localparam int PW = DIN_WIDTH + ERR_WIDTH;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] step;
  logic signed [PW:0]   sum;
  logic signed [63:0]   sum_wide;

  // Multiply at full product width, floor-shift, widen by one bit and clamp.
  always_comb begin
    prod       = $signed({{ERR_WIDTH{x[DIN_WIDTH-1]}}, x}) *
                 $signed({{DIN_WIDTH{err[ERR_WIDTH-1]}}, err});
    step       = prod >>> MU_SHIFT;
    sum        = $signed({step[PW-1], step}) +
                 $signed({{(PW + 1 - DIN_WIDTH){coeff[DIN_WIDTH-1]}}, coeff});
    sum_wide   = $signed({{(64 - PW - 1){sum[PW]}}, sum});
    coeff_next = DIN_WIDTH'(sat_to(sum_wide, DIN_WIDTH));
  end

endmodule

// File: rtl/lms_coeff_update.sv
// LMS coefficient adaptation: keeps a private delay line of the FIR input and,
// per error sample, walks the taps one per clock applying w[k] += (err*x[k]) >>> MU.
module lms_coeff_update
  import lms_pkg::*;
#(
  parameter int DIN_WIDTH = DEF_DIN_WIDTH,
  parameter int ERR_WIDTH = DEF_ERR_WIDTH,
  parameter int TAPS      = DEF_TAPS,
  parameter int MU_SHIFT  = DEF_MU_SHIFT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_valid,
  input  logic signed [DIN_WIDTH-1:0] din,
  input  logic                        err_valid,
  input  logic signed [ERR_WIDTH-1:0] err,
  input  logic                        coeff_load,
  input  logic [TAPS*DIN_WIDTH-1:0]   coeff_init,
  output logic [TAPS*DIN_WIDTH-1:0]   coeffs,
  output logic                        busy,
  output logic                        update_done,
  output logic                        overrun
);

  localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);

  state_t                      state;
  state_t                      state_next;
  logic [IW-1:0]               idx;
  logic signed [ERR_WIDTH-1:0] err_q;
  logic signed [DIN_WIDTH-1:0] dline [TAPS];
  logic signed [DIN_WIDTH-1:0] coef  [TAPS];
  logic                        pend_valid;
  logic signed [DIN_WIDTH-1:0] pend_data;

  logic                        shift_en;
  logic signed [DIN_WIDTH-1:0] shift_data;
  logic                        pend_store;
  logic                        pend_clear;
  logic                        lost;
  logic                        load_en;
  logic                        start;
  logic signed [DIN_WIDTH-1:0] mac_out;

  // Next-state and side-effect decode for the IDLE / UPDATE / DONE sequencer.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    shift_data = din;
    pend_store = 1'b0;
    pend_clear = 1'b0;
    lost       = 1'b0;
    load_en    = 1'b0;
    start      = 1'b0;
    case (state)
      ST_IDLE: begin
        shift_en = sample_valid;
        if (coeff_load) begin
          load_en = 1'b1;
        end else if (err_valid) begin
          start      = 1'b1;
          state_next = ST_UPDATE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        pend_store = sample_valid && !pend_valid;
        lost       = (sample_valid && pend_valid) || err_valid;
        state_next = (idx == LAST_IDX) ? ST_DONE : ST_UPDATE;
      end
      ST_DONE: begin
        // A sample arriving in DONE with nothing pending goes straight in,
        // since this is the edge on which the pending slot drains.
        shift_en   = pend_valid || sample_valid;
        shift_data = pend_valid ? pend_data : din;
        pend_clear = pend_valid;
        lost       = (sample_valid && pend_valid) || err_valid;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, tap index, captured error, pending sample and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= {IW{1'b0}};
      err_q       <= {ERR_WIDTH{1'b0}};
      pend_valid  <= 1'b0;
      pend_data   <= {DIN_WIDTH{1'b0}};
      busy        <= 1'b0;
      update_done <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_next;
      busy        <= (state_next == ST_UPDATE);
      update_done <= (state_next == ST_DONE);
      if (start) begin
        err_q <= err;
        idx   <= {IW{1'b0}};
      end else if (state == ST_UPDATE) begin
        idx <= idx + IW'(1);
      end else begin
        idx <= idx;
      end
      if (pend_store) begin
        pend_valid <= 1'b1;
        pend_data  <= din;
      end else if (pend_clear) begin
        pend_valid <= 1'b0;
      end else begin
        pend_valid <= pend_valid;
      end
      if (lost) begin
        overrun <= 1'b1;
      end else begin
        overrun <= overrun;
      end
    end
  end

  // Input delay line, x[0] newest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        dline[k] <= {DIN_WIDTH{1'b0}};
      end
    end else if (shift_en) begin
      dline[0] <= shift_data;
      for (int k = 1; k < TAPS; k++) begin
        dline[k] <= dline[k-1];
      end
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        dline[k] <= dline[k];
      end
    end
  end

  lms_sat_mac #(
    .DIN_WIDTH(DIN_WIDTH),
    .ERR_WIDTH(ERR_WIDTH),
    .MU_SHIFT (MU_SHIFT)
  ) u_mac (
    .coeff     (coef[idx]),
    .x         (dline[idx]),
    .err       (err_q),
    .coeff_next(mac_out)
  );

  // Coefficient bank: bulk load in IDLE, one tap written per UPDATE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        coef[k] <= {DIN_WIDTH{1'b0}};
      end
    end else if (load_en) begin
      for (int k = 0; k < TAPS; k++) begin
        coef[k] <= coeff_init[k*DIN_WIDTH +: DIN_WIDTH];
      end
    end else if (state == ST_UPDATE) begin
      coef[idx] <= mac_out;
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        coef[k] <= coef[k];
      end
    end
  end

  for (genvar g = 0; g < TAPS; g++) begin : g_pack
    assign coeffs[g*DIN_WIDTH +: DIN_WIDTH] = coef[g];
  end

endmodule

// File: tb/tb_lms_coeff_update.sv
// Directed and model-checked stimulus for lms_coeff_update with default sizes
// (16-bit data/error, 8 taps, mu = 2^-10).
module tb_lms_coeff_update;
  import lms_pkg::*;

  localparam int DW = 16;
  localparam int EW = 16;
  localparam int NT = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sample_valid;
  logic signed [DW-1:0] din;
  logic                 err_valid;
  logic signed [EW-1:0] err;
  logic                 coeff_load;
  logic [NT*DW-1:0]     coeff_init;
  logic [NT*DW-1:0]     coeffs;
  logic                 busy;
  logic                 update_done;
  logic                 overrun;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint m_x [NT];
  longint m_w [NT];

  always #5 clk = ~clk;

  lms_coeff_update dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .din         (din),
    .err_valid   (err_valid),
    .err         (err),
    .coeff_load  (coeff_load),
    .coeff_init  (coeff_init),
    .coeffs      (coeffs),
    .busy        (busy),
    .update_done (update_done),
    .overrun     (overrun)
  );

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] coef_of(input int k);
    return $signed(coeffs[k*DW +: DW]);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NT; k++) begin
      m_x[k] = 0;
      m_w[k] = 0;
    end
  endtask

  task automatic model_shift(input longint v);
    for (int k = NT - 1; k > 0; k--) m_x[k] = m_x[k-1];
    m_x[0] = v;
  endtask

  task automatic model_update(input longint e);
    for (int k = 0; k < NT; k++) begin
      logic signed [PROD_WIDTH-1:0] p;
      longint s;
      p = PROD_WIDTH'(e * m_x[k]);
      s = longint'(p >>> 10);
      s = m_w[k] + s;
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      m_w[k] = s;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < (1 << IDX_WIDTH); k++)
      check($sformatf("%s_w%0d", tag, k), coef_of(k), m_w[k]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    err_valid = 1'b0;
    coeff_load = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc();
  endtask

  task automatic push(input longint v);
    sample_valid = 1'b1;
    din = DW'(v);
    cyc();
    sample_valid = 1'b0;
    model_shift(v);
  endtask

  task automatic load_all(input longint v);
    for (int k = 0; k < NT; k++) coeff_init[k*DW +: DW] = DW'(v);
    coeff_load = 1'b1;
    cyc();
    coeff_load = 1'b0;
    for (int k = 0; k < NT; k++) m_w[k] = v;
  endtask

  task automatic start_err(input longint e);
    err_valid = 1'b1;
    err = EW'(e);
    cyc();
    err_valid = 1'b0;
    model_update(e);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (update_done !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    check({tag, "_done_seen"}, update_done, 1);
    cyc();
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    rst = 1'b1;
    sample_valid = 1'b0;
    din = '0;
    err_valid = 1'b0;
    err = '0;
    coeff_load = 1'b0;
    coeff_init = '0;
    #7;
    check("rst_coeffs", coeffs, 0);
    check("rst_busy", busy, 0);
    check("rst_done", update_done, 0);
    check("rst_overrun", overrun, 0);

    // Basic update with latency and pulse counting.
    do_reset();
    for (int i = 0; i < NT; i++) push(1024);
    start_err(1024);
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      busy_cnt += int'(busy);
      done_cnt += int'(update_done);
      if (i == 0) check("lat_w0_before", coef_of(0), 0);
      if (i == 1) check("lat_w0_after", coef_of(0), 1024);
      if (i == 1) check("lat_w1_before", coef_of(1), 0);
      if (i == 8) check("lat_done_edge", update_done, 1);
      cyc();
    end
    check("basic_busy_cycles", busy_cnt, 8);
    check("basic_done_pulses", done_cnt, 1);
    check_all("basic");
    check("basic_w7_const", coef_of(7), 1024);

    // Floor rounding of a negative product.
    do_reset();
    push(1);
    start_err(-1);
    wait_done("floor");
    check("floor_w0", coef_of(0), -1);
    check_all("floor");

    // Positive and negative saturation.
    do_reset();
    load_all(32767);
    for (int i = 0; i < NT; i++) push(32767);
    start_err(32767);
    wait_done("satp");
    check("satp_w5", coef_of(5), 32767);
    check_all("satp");
    load_all(-32768);
    start_err(-32768);
    wait_done("satn");
    check("satn_w2", coef_of(2), -32768);
    check_all("satn");

    // coeff_load beats err_valid in IDLE; the error is dropped silently.
    do_reset();
    for (int k = 0; k < NT; k++) coeff_init[k*DW +: DW] = DW'(300);
    coeff_load = 1'b1;
    err_valid = 1'b1;
    err = EW'(1000);
    cyc();
    coeff_load = 1'b0;
    err_valid = 1'b0;
    for (int k = 0; k < NT; k++) m_w[k] = 300;
    check("prio_busy", busy, 0);
    check("prio_overrun", overrun, 0);
    check_all("prio");

    // Sample arriving mid-update is held until DONE.
    do_reset();
    for (int i = 1; i <= NT; i++) push(i);
    start_err(1024);
    cyc();
    cyc();
    sample_valid = 1'b1;
    din = DW'(5);
    cyc();
    sample_valid = 1'b0;
    wait_done("mid");
    model_shift(5);
    check("mid_overrun", overrun, 0);
    check_all("mid");
    start_err(1024);
    wait_done("mid2");
    check("mid2_w1", coef_of(1), 15);
    check_all("mid2");

    // Second sample during one update is dropped.
    start_err(1024);
    cyc();
    sample_valid = 1'b1;
    din = DW'(77);
    cyc();
    din = DW'(99);
    cyc();
    sample_valid = 1'b0;
    wait_done("drop");
    model_shift(77);
    check("drop_overrun", overrun, 1);
    start_err(1024);
    wait_done("drop2");
    check_all("drop2");

    // err_valid and coeff_load while busy are ignored.
    do_reset();
    for (int i = 1; i <= NT; i++) push(10 * i);
    start_err(2048);
    cyc();
    err_valid = 1'b1;
    err = EW'(-5000);
    cyc();
    err_valid = 1'b0;
    for (int k = 0; k < NT; k++) coeff_init[k*DW +: DW] = DW'(555);
    coeff_load = 1'b1;
    cyc();
    coeff_load = 1'b0;
    wait_done("coll");
    check("coll_overrun", overrun, 1);
    check("coll_w0", coef_of(0), 160);
    check_all("coll");

    // Reset in the middle of an update.
    do_reset();
    load_all(1000);
    for (int i = 1; i <= NT; i++) push(2000 * i);
    start_err(4096);
    for (int i = 0; i < 4; i++) cyc();
    rst = 1'b1;
    #1;
    model_reset();
    check("mrst_busy", busy, 0);
    check("mrst_coeffs", coeffs, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    for (int i = 1; i <= NT; i++) push(-300 * i);
    start_err(-7000);
    wait_done("mrst");
    check_all("mrst");

    // Random stream against the reference model, some errors coincident with a sample.
    do_reset();
    for (int i = 0; i < 901; i++) begin
      longint v;
      v = longint'($signed(16'($urandom_range(0, 65535))));
      if ($urandom_range(0, 5) == 0) begin
        longint e;
        e = longint'($signed(16'($urandom_range(0, 65535))));
        sample_valid = 1'b1;
        din = DW'(v);
        err_valid = 1'b1;
        err = EW'(e);
        cyc();
        sample_valid = 1'b0;
        err_valid = 1'b0;
        model_shift(v);
        model_update(e);
        wait_done("rnd");
        check_all("rnd");
      end else begin
        push(v);
      end
    end
    check("rnd_overrun", overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lms_coeff_update.md
Name: lms_coeff_update

Overview:
- LMS coefficient-adaptation stage that sits directly upstream of transposed_fir and drives its coeffs bus.
- Keeps its own TAPS-deep delay line of input samples.
- On each error sample, serially applies w[k] += (err*x[k]) >>> MU_SHIFT, one tap per clock, with saturation.
- Buffers one input sample that arrives mid-update so the delay line stays consistent with the error being applied.

Parameters:
- DIN_WIDTH, 16, sample and coefficient width, signed.
- ERR_WIDTH, 16, error sample width, signed.
- TAPS, 8, number of coefficients; must be >= 2.
- MU_SHIFT, 10, step size mu = 2^-MU_SHIFT, implemented as an arithmetic right shift.

Ports:
- clk, in, 1, clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- sample_valid, in, 1, din valid this cycle.
- din, in, DIN_WIDTH, input sample, signed; same stream fed to the FIR.
- err_valid, in, 1, err valid this cycle.
- err, in, ERR_WIDTH, error sample (desired minus FIR output), signed.
- coeff_load, in, 1, load coeff_init into all coefficients.
- coeff_init, in, TAPS x DIN_WIDTH, packed initial coefficients.
- coeffs, out, TAPS x DIN_WIDTH, packed coefficients; coeffs[0] pairs with the newest sample.
- busy, out, 1, update in progress.
- update_done, out, 1, one-cycle pulse after the last tap is written.
- overrun, out, 1, sticky; set when an input was lost.

Behaviour:
- Reset (asynchronous, rst=1):
  - coeffs, delay line, pending register and captured err all go to 0.
  - State = IDLE; busy=0, update_done=0, overrun=0.
- Delay line x[0..TAPS-1], x[0] newest. In IDLE, on sample_valid: x[0]<=din, x[k]<=x[k-1].
- States:
  - IDLE -> UPDATE on err_valid, when coeff_load=0. err is captured and the tap index k=0.
  - UPDATE: each cycle coeffs[k] <= sat(coeffs[k] + ((err*x[k]) >>> MU_SHIFT)), then k++. After k=TAPS-1 is written -> DONE.
  - DONE: one cycle. update_done=1, busy=0, then -> IDLE.
- Latency: err accepted on edge E.
  - coeffs[k] changes on edge E+1+k.
  - update_done is high for the cycle following edge E+TAPS.
  - busy is high from edge E until edge E+TAPS.
- Arithmetic:
  - Product is signed, DIN_WIDTH+ERR_WIDTH bits.
  - Shift is arithmetic, i.e. floor; -1 >>> 10 = -1.
  - Sum is computed at product width+1, then saturated to [-2^(DIN_WIDTH-1), 2^(DIN_WIDTH-1)-1].
- sample_valid while busy or in DONE:
  - The first sample is stored in a one-entry pending register.
  - It is shifted into the delay line on the DONE->IDLE edge.
  - If a second sample arrives while one is pending, it is dropped and overrun is set.
- sample_valid in IDLE together with err_valid: the shift happens first; the update uses the post-shift delay line.
- err_valid while busy or in DONE: ignored; overrun is set.
- coeff_load:
  - Honoured only in IDLE; it has priority over err_valid, and that err is dropped without setting overrun.
  - All coeffs <= coeff_init on the next edge.
  - While busy, coeff_load is ignored.
- overrun is cleared only by rst.
- rst mid-update: coeffs return to 0 immediately; no partial state survives.

Decomposition:
- Package lms_pkg holds:
  - state enum (IDLE, UPDATE, DONE);
  - function sat_to(width);
  - derived localparams PROD_WIDTH = DIN_WIDTH+ERR_WIDTH and IDX_WIDTH = $clog2(TAPS).
- One sub-module, lms_sat_mac: combinational multiply, arithmetic shift, add and saturate for a single tap. Instantiated once and time-shared across taps by the index counter.

Test Plan:
- Basic update: reset; 8 samples of 1024; err=1024 -> after 8 cycles every coeff = 1024, update_done pulses exactly once, busy high for 8 cycles.
- Floor rounding: one sample x[0]=1, rest 0; err=-1 -> coeffs[0] = -1, all others stay 0.
- Positive saturation: coeff_load all 32767; x all 32767; err=32767 -> all coeffs stay 32767 with no wrap. Negative case: err=-32768 with x=32767 and coeffs -32768 -> all coeffs stay -32768.
- Mid-update sample: err accepted, then din=5 at cycle 3 of UPDATE -> x[0] unchanged during UPDATE, x[0]=5 after DONE, overrun=0. A second sample during the same update -> dropped, overrun=1.
- Busy collisions: err_valid during UPDATE -> ignored, coeffs match the single-update golden, overrun=1. coeff_load during UPDATE -> ignored.
- Reset mid-update: assert rst at tap 4 -> coeffs all 0 asynchronously, busy=0, a fresh update afterwards matches the golden model.
- Bench check: per-tap comparison of coeffs against a reference model across a 901-sample random stream.
